// File: rtl/rtl_cnt_stamp.sv
// Timestamp capture stage: extends the free-running counter with a wrap epoch,
// stamps each event as {epoch, counter}, and queues stamps for valid/ready readout.
module rtl_cnt_stamp #(
  parameter int N     = 64,
  parameter int E     = 8,
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [N-1:0]   counter,
  input  logic           cout,
  input  logic           evt,
  output logic [E+N-1:0] ts_data,
  output logic           ts_valid,
  input  logic           ts_ready,
  output logic           full,
  output logic           overflow,
  output logic [DW-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [E+N-1:0] stamp_t;

  logic [E-1:0]  epoch_q, epoch_d, epoch_eff;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  stamp_t        mem_q [DEPTH];
  stamp_t        mem_d [DEPTH];
  stamp_t        ts_data_q, ts_data_d, sample;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic          full_w, pop, push, drop;

  always_comb begin
    epoch_eff = epoch_q + E'(cout);
    epoch_d   = epoch_eff;
    sample    = {epoch_eff, counter};

    full_w = (count_q == CW'(DEPTH));
    pop    = (count_q != '0) & ts_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push   = evt & (~full_w | pop);
    drop   = evt & full_w & ~pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = sample;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // The head is registered so ts_data never depends on ts_ready combinationally.
    ts_data_d = (count_d != '0) ? mem_d[rd_ptr_d] : ts_data_q;

    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q + DW'(drop && (drop_cnt_q != '1));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      epoch_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ts_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      epoch_q    <= epoch_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ts_data_q  <= ts_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is left unreset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ts_data  = ts_data_q;
  assign ts_valid = (count_q != '0);
  assign full     = full_w;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/rtl_cnt_stamp.md
Name: rtl_cnt_stamp

Overview:
- Downstream consumer of the lazy-carry free-running counter (`counter`, `cout`).
- Extends the N-bit count with an E-bit epoch, which is incremented on every counter wrap (`cout`).
- Captures a timestamp {epoch, counter} on each input event.
- Buffers timestamps in a small FIFO and drains them over a valid/ready stream to the readout logic.

Parameters:
- N, 64, width of the incoming counter.
- E, 8, epoch (wrap-count) width; the epoch wraps modulo 2^E.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DW, 16, width of the dropped-event counter.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- counter  in  N  counter value from the counter stage (registered there)
- cout  in  1  wrap pulse from the counter stage; high in the cycle `counter` shows the wrapped value
- event  in  1  capture request, single-cycle pulse per event, already synchronous to clk
- ts_data  out  E+N  timestamp {epoch, counter}
- ts_valid  out  1  ts_data holds a valid entry
- ts_ready  in  1  downstream accepts ts_data
- full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: at least one event dropped since reset
- drop_cnt  out  DW  number of dropped events, saturating at 2^DW-1

Behaviour:
- Reset (nrst=0 at posedge): epoch_q=0, FIFO emptied (rd/wr pointers 0, count 0), ts_valid=0, ts_data=0, full=0, overflow=0, drop_cnt=0. Reset has priority over all other activity, including an in-flight event or handshake.
- Epoch tracking:
  - epoch_eff = epoch_q + cout, computed mod 2^E, combinational.
  - epoch_q <= epoch_eff every cycle.
  - An event coinciding with cout=1 therefore captures the incremented epoch together with the wrapped counter value.
- Capture: sample = {epoch_eff, counter}, taken in the cycle event=1.
- Pop: pop = ts_valid & ts_ready.
- Push:
  - push = event & (!full | pop). When full, a same-cycle pop frees a slot, so the push is accepted.
  - event=1 with full=1 and pop=0 -> event dropped, no FIFO state change.
  - On a drop: overflow <= 1 (sticky until reset); drop_cnt <= drop_cnt+1 unless already all-ones (saturates, never wraps).
- FIFO:
  - Registered storage with wrap-around rd/wr pointers (log2(DEPTH) bits) and a count of log2(DEPTH)+1 bits.
  - count_next = count + push - pop.
  - full = (count==DEPTH); ts_valid = (count!=0). Both derive from registered state.
- Latency: event at cycle t into an empty FIFO -> ts_valid=1 and ts_data=sample from cycle t+1.
- Output stability: while ts_valid=1 and ts_ready=0, ts_data and ts_valid hold unchanged.
- Ordering: strictly first-in first-out; no reordering or merging.
- Ready while empty: ts_ready=1 with ts_valid=0 has no effect. Data pushed in cycle t is not visible until t+1; there is no combinational bypass.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged, head advances, new entry appended at the tail.
- ts_data when ts_valid=0: don't-care for consumers, but holds the last value (or 0 after reset), never X.
- Counter-stage reset: the counter stage is reset by the same nrst, so epoch and counter restart coherently.
- Timing: no combinational path from ts_ready to ts_valid or ts_data. The only combinational input->output path is none; all outputs are registered or decoded from registers.
- Target size: 150-250 lines.

Test Plan:
- Basic capture:
  - Stimulus: reset, drive counter=0x10, cout=0, event=1 for one cycle, ts_ready=1.
  - Required: next cycle ts_valid=1, ts_data={8'h00, 64'h10}; the cycle after, ts_valid=0.
- Wrap coincidence:
  - Stimulus: epoch_q=0x03, then counter=0 with cout=1 and event=1 in the same cycle.
  - Required: captured ts_data={8'h04, 64'h0}; epoch_q=0x04 afterwards.
  - Stimulus: 256 cout pulses from epoch 0.
  - Required: epoch returns to 0x00.
- Backpressure and fill:
  - Stimulus: ts_ready=0, four events with counter=1,2,3,4.
  - Required: full=1 after the 4th; a 5th event is dropped, giving overflow=1 and drop_cnt=1.
  - Stimulus: then ts_ready=1.
  - Required: outputs 1,2,3,4 in order on consecutive cycles, then ts_valid=0; overflow stays 1.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full (1..4), ts_ready=1 and event with counter=5 in the same cycle.
  - Required: no drop (drop_cnt unchanged), full stays 1, drain order 2,3,4,5.
- Drop saturation:
  - Stimulus: DW=4, FIFO full, ts_ready=0, 20 events.
  - Required: drop_cnt=15 and holds at 15.
- Reset mid-operation:
  - Stimulus: FIFO holding 3 entries, ts_ready=0, overflow=1; assert nrst=0 for one cycle together with event=1.
  - Required: next cycle ts_valid=0, full=0, overflow=0, drop_cnt=0, epoch_q=0; the event is not captured.
